hm_seq: RTL
===========

HM_SEQ -- requirements
Module: hm_seq

Interface
REQ-001 Parameters SHALL be: csr_addr, default 4'h0, CSR bank select; PAGE_BITS, default 12, log2 page size; CNT_W, default 8, page-count width; RETRY_MAX, default 3, retries per page; WD_W, default 16, watchdog width.
REQ-002 sys_clk  in  1  sole clock; all logic is on the rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 csr_a  in  14; csr_we  in  1; csr_di  in  32; csr_do  out  32  CSR bus.
REQ-005 req_start  out  1  one-cycle request pulse to the page fetch engine.
REQ-006 req_addr  out  64  page base address; bits [PAGE_BITS-1:0] are always zero.
REQ-007 req_end  in  1  engine reports the page was fetched; req_timeout  in  1  engine reports a timeout.
REQ-008 irq  out  1  level interrupt.

Function
REQ-009 CSR bank selected when csr_a[13:10]==csr_addr; csr_do registered, 1-cycle latency, 0 when not selected or address unmapped.
REQ-010 Offsets: 0 STAT; 1 CTRL; 2 ADDR_LO; 3 ADDR_HI; 4 PAGES; 5 DONE_CNT (RO); 6 RETRY_CNT (RO); 7 STATE (RO).
REQ-011 STAT: bit0 event_end, bit1 event_error, bit2 busy (RO); bits 0-1 write-one-to-clear; set-event wins over a same-cycle clear.
REQ-012 CTRL: bit0 irq_en (R/W), bit1 start (write pulse, reads 0), bit2 abort (write pulse, reads 0).
REQ-013 ADDR_LO, ADDR_HI and PAGES writes are ignored while busy; ADDR_LO bits [PAGE_BITS-1:0] are stored as zero.
REQ-014 FSM states are IDLE, ISSUE, WAIT and DONE; busy is high whenever the state is not IDLE.
REQ-015 IDLE + start: if PAGES==0, go to DONE without issuing any request; otherwise load cur_addr=ADDR, clear DONE_CNT and RETRY_CNT, go to ISSUE.
REQ-016 ISSUE: drive req_start high for exactly one cycle, clear the watchdog, go to WAIT.
REQ-017 req_addr SHALL equal cur_addr and stay stable from ISSUE until WAIT exits.
REQ-018 WAIT + req_end: DONE_CNT++, cur_addr += 2^PAGE_BITS modulo 2^64, clear per-page retries; go to DONE if DONE_CNT==PAGES, else ISSUE.
REQ-019 WAIT + (req_timeout or watchdog saturating at 2^WD_W-1): if per-page retries < RETRY_MAX, increment the per-page retries and RETRY_CNT and go to ISSUE; otherwise set event_error and go to IDLE.
REQ-020 req_end and req_timeout in the same cycle: req_end wins.
REQ-021 DONE: set event_end for one cycle, go to IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 abort in any non-IDLE state: go to IDLE next cycle and set event_error; late req_end or req_timeout in IDLE SHALL be ignored.
REQ-024 irq = irq_en & (event_end | event_error).
REQ-025 RETRY_CNT saturates at all-ones (32 bits).

Reset
REQ-026 sys_rst SHALL force IDLE, csr_do=0, req_start=0, req_addr=0, irq=0, and clear all events, irq_en, ADDR, PAGES and all counters.
REQ-027 Reset asserted mid-sequence SHALL abort it with no event raised.

Structure
REQ-028 CSR offsets, STAT/CTRL bit positions and FSM state encodings SHALL live in the shared hm package header alongside the existing HM_ defines.
REQ-029 One sub-module, hm_seq_wd (a loadable saturating watchdog counter), is natural; everything else is flat.

Verification
REQ-030 ADDR=0x1_0000_0000, PAGES=3, engine acks each request after 5 cycles -> req_addr sequence 0x1_0000_0000, 0x1_0000_1000, 0x1_0000_2000; DONE_CNT=3; event_end=1; irq=1 when irq_en=1.
REQ-031 PAGES=2, first request gets req_timeout twice then req_end -> 4 req_start pulses total; RETRY_CNT=2; event_end=1.
REQ-032 PAGES=1, engine silent, WD_W=4 -> RETRY_MAX+1=4 requests, each retried after 15 cycles; then event_error=1 and IDLE.
REQ-033 ADDR=0xFFFF_FFFF_FFFF_F000, PAGES=2 -> second req_addr=0; ADDR_LO write of 0x123 reads back 0x000.
REQ-034 PAGES=0 + start -> no req_start; event_end asserted within 2 cycles; then abort during WAIT -> IDLE next cycle, event_error=1, and a subsequent req_end is ignored.

Source files
------------

// File: rtl/hm_seq_pkg.sv
// Shared hm package: CSR offsets, STAT/CTRL bit positions and sequencer state encodings.
package hm_seq_pkg;

  localparam int unsigned HM_CSR_AW = 14;
  localparam int unsigned HM_OFF_W  = 10;

  localparam logic [HM_OFF_W-1:0] HM_OFF_STAT      = 10'd0;
  localparam logic [HM_OFF_W-1:0] HM_OFF_CTRL      = 10'd1;
  localparam logic [HM_OFF_W-1:0] HM_OFF_ADDR_LO   = 10'd2;
  localparam logic [HM_OFF_W-1:0] HM_OFF_ADDR_HI   = 10'd3;
  localparam logic [HM_OFF_W-1:0] HM_OFF_PAGES     = 10'd4;
  localparam logic [HM_OFF_W-1:0] HM_OFF_DONE_CNT  = 10'd5;
  localparam logic [HM_OFF_W-1:0] HM_OFF_RETRY_CNT = 10'd6;
  localparam logic [HM_OFF_W-1:0] HM_OFF_STATE     = 10'd7;

  localparam int unsigned HM_STAT_END  = 0;
  localparam int unsigned HM_STAT_ERR  = 1;
  localparam int unsigned HM_STAT_BUSY = 2;

  localparam int unsigned HM_CTRL_IRQ_EN = 0;
  localparam int unsigned HM_CTRL_START  = 1;
  localparam int unsigned HM_CTRL_ABORT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } hm_state_e;

  // Mask that clears the in-page offset bits of the low address word.
  function automatic logic [31:0] hm_page_mask(input int unsigned page_bits);
    return ~((32'd1 << page_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/hm_seq_wd.sv
// Loadable saturating watchdog counter; sat stays high once the count reaches all-ones.
module hm_seq_wd #(
  parameter int unsigned WD_W = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            load,
  input  logic            en,
  input  logic [WD_W-1:0] load_val,
  output logic            sat
);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !sat) begin
      cnt <= cnt + WD_W'(1);
    end
  end

  assign sat = &cnt;

endmodule

// File: rtl/hm_seq.sv
// Page fetch sequencer: CSR-programmed base/page count, issues one request per page
// with per-page retry on timeout or watchdog expiry, and raises end/error events.
module hm_seq
  import hm_seq_pkg::*;
#(
  parameter logic [3:0]  csr_addr  = 4'h0,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned WD_W      = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        req_start,
  output logic [63:0] req_addr,
  input  logic        req_end,
  input  logic        req_timeout,
  output logic        irq
);

  localparam int unsigned     RW        = $clog2(RETRY_MAX + 2);
  localparam logic [RW-1:0]   RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [31:0]     LO_MASK   = hm_page_mask(PAGE_BITS);
  localparam logic [63:0]     PAGE_INC  = 64'd1 << PAGE_BITS;

  hm_state_e state, nxt;

  logic [31:0]       addr_lo, addr_hi, retry_cnt, rd_data;
  logic [CNT_W-1:0]  pages, done_cnt, done_inc;
  logic [RW-1:0]     page_retry;
  logic [63:0]       cur_addr;
  logic              event_end, event_error, irq_en, busy;
  logic              csr_sel, csr_wr, stat_wr, ctrl_wr, start_req, abort_req;
  logic              wd_sat, wd_load, wd_en;
  logic              load_seq, inc_done, inc_retry, set_end, set_err;
  logic [9:0]        off;

  assign off       = csr_a[9:0];
  assign csr_sel   = (csr_a[13:10] == csr_addr);
  assign csr_wr    = csr_sel && csr_we;
  assign stat_wr   = csr_wr && (off == HM_OFF_STAT);
  assign ctrl_wr   = csr_wr && (off == HM_OFF_CTRL);
  assign start_req = ctrl_wr && csr_di[HM_CTRL_START];
  assign abort_req = ctrl_wr && csr_di[HM_CTRL_ABORT];
  assign busy      = (state != ST_IDLE);
  assign done_inc  = done_cnt + CNT_W'(1);
  assign wd_en     = (state == ST_WAIT);

  hm_seq_wd #(.WD_W(WD_W)) u_wd (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (wd_load),
    .en       (wd_en),
    .load_val ('0),
    .sat      (wd_sat)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt       = state;
    load_seq  = 1'b0;
    wd_load   = 1'b0;
    inc_done  = 1'b0;
    inc_retry = 1'b0;
    set_end   = 1'b0;
    set_err   = 1'b0;
    if (abort_req && busy) begin
      nxt     = ST_IDLE;
      set_err = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (pages == '0) begin
              nxt = ST_DONE;
            end else begin
              load_seq = 1'b1;
              nxt      = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wd_load = 1'b1;
          nxt     = ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a same-cycle timeout.
          if (req_end) begin
            inc_done = 1'b1;
            nxt      = (done_inc == pages) ? ST_DONE : ST_ISSUE;
          end else if (req_timeout || wd_sat) begin
            if (page_retry < RETRY_LIM) begin
              inc_retry = 1'b1;
              nxt       = ST_ISSUE;
            end else begin
              set_err = 1'b1;
              nxt     = ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          set_end = 1'b1;
          nxt     = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      addr_lo     <= '0;
      addr_hi     <= '0;
      pages       <= '0;
      irq_en      <= 1'b0;
      event_end   <= 1'b0;
      event_error <= 1'b0;
      cur_addr    <= '0;
      done_cnt    <= '0;
      retry_cnt   <= '0;
      page_retry  <= '0;
    end else begin
      if (ctrl_wr) irq_en <= csr_di[HM_CTRL_IRQ_EN];
      if (csr_wr && !busy) begin
        case (off)
          HM_OFF_ADDR_LO: addr_lo <= csr_di & LO_MASK;
          HM_OFF_ADDR_HI: addr_hi <= csr_di;
          HM_OFF_PAGES:   pages   <= csr_di[CNT_W-1:0];
          default: ;
        endcase
      end
      // Event set takes priority over write-one-to-clear in the same cycle.
      event_end   <= set_end | (event_end   & ~(stat_wr & csr_di[HM_STAT_END]));
      event_error <= set_err | (event_error & ~(stat_wr & csr_di[HM_STAT_ERR]));
      if (load_seq) begin
        cur_addr   <= {addr_hi, addr_lo};
        done_cnt   <= '0;
        retry_cnt  <= '0;
        page_retry <= '0;
      end
      if (inc_done) begin
        done_cnt   <= done_inc;
        cur_addr   <= cur_addr + PAGE_INC;
        page_retry <= '0;
      end
      if (inc_retry) begin
        page_retry <= page_retry + RW'(1);
        if (retry_cnt != '1) retry_cnt <= retry_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      HM_OFF_STAT:      rd_data = {29'd0, busy, event_error, event_end};
      HM_OFF_CTRL:      rd_data = {31'd0, irq_en};
      HM_OFF_ADDR_LO:   rd_data = addr_lo;
      HM_OFF_ADDR_HI:   rd_data = addr_hi;
      HM_OFF_PAGES:     rd_data = 32'(pages);
      HM_OFF_DONE_CNT:  rd_data = 32'(done_cnt);
      HM_OFF_RETRY_CNT: rd_data = retry_cnt;
      HM_OFF_STATE:     rd_data = 32'(state);
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) csr_do <= '0;
    else         csr_do <= csr_sel ? rd_data : '0;
  end

  assign req_start = (state == ST_ISSUE);
  assign req_addr  = cur_addr;
  assign irq       = irq_en & (event_end | event_error);

endmodule
